// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
//   Shared types for the stopwatch controller: FSM state codes, BCD digit
//   type and the six-digit display bundle.
//   Optional feature macro used by the importing files: STOPWATCH_LAP_EN.
package stopwatch_pkg;

  // State codes are visible on state_o, so the encoding is fixed.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_LAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t MAX_BCD = 4'd9;

  typedef struct packed {
    bcd_t min;
    bcd_t seg2;
    bcd_t seg1;
    bcd_t deci;
    bcd_t centi;
    bcd_t milli;
  } digits_t;

endpackage

// File: rtl/stopwatch_ctrl_tick_gen.sv
// tick_gen
//   Count-enable divider. Counts 0..DIV-1 while run is high, holds its value
//   while run is low (keeps the tick phase across a pause), and returns to 0
//   on clr. tick is high for the one cycle the divider sits at DIV-1 while
//   running.
// Ports
//   clk   in  clock
//   reset in  asynchronous, active-high reset
//   run   in  advance the divider this cycle
//   clr   in  zero the divider (wins over run)
//   tick  out divider terminal count while running
module tick_gen #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int W   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q;
    if (clr)
      div_d = '0;
    else if (run)
      div_d = (div_q == LAST) ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_q <= '0;
    else       div_q <= div_d;
  end

  assign tick = run && (div_q == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Control FSM for the 6-digit BCD stopwatch counter. Turns the debounced
//   start/stop, lap and clear buttons into count-enable / clear pulses for
//   the counter, stops at the minute limit and drives the display digits
//   (live, or a frozen lap capture).
//   Build option: define STOPWATCH_LAP_EN to get the lap button and lap
//   capture; without it btn_lap does not exist and the display is always live.
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   btn_ss/btn_lap/btn_clr  debounced button levels, asynchronous to clk
//   *_in                 live counter digits (BCD)
//   cnt_en, cnt_clr      one-cycle pulses to the counter
//   disp_*               registered display digits
//   state_o, done        FSM state code, high in DONE
//
// state | meaning
// IDLE  | stopped and cleared, waiting for start
// RUN   | counting, display live
// PAUSE | counting held, divider phase kept
// LAP   | counting, display frozen on the lap capture
// DONE  | minute limit reached, waiting for clear
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 1000,
  parameter int LIMIT_MIN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
`ifdef STOPWATCH_LAP_EN
  input  logic       btn_lap,
`endif
  input  logic       btn_clr,
  input  logic [3:0] min_in,
  input  logic [3:0] seg2_in,
  input  logic [3:0] seg1_in,
  input  logic [3:0] deci_in,
  input  logic [3:0] centi_in,
  input  logic [3:0] milli_in,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic [3:0] disp_min,
  output logic [3:0] disp_seg2,
  output logic [3:0] disp_seg1,
  output logic [3:0] disp_deci,
  output logic [3:0] disp_centi,
  output logic [3:0] disp_milli,
  output logic [2:0] state_o,
  output logic       done
);

  localparam bcd_t LIMIT = bcd_t'(LIMIT_MIN);

  state_e     state_q, state_d;
  logic [2:0] ss_sync_q, ss_sync_d, clr_sync_q, clr_sync_d;
  logic       ss_ev, clr_ev, lap_ev;
  logic       running, limit_hit, clr_take, div_clr, tick;
  logic       cnt_en_q, cnt_en_d, cnt_clr_q, cnt_clr_d;
  digits_t    live, disp_q, disp_d;

  assign live = '{min: min_in, seg2: seg2_in, seg1: seg1_in,
                  deci: deci_in, centi: centi_in, milli: milli_in};

  // Bits [1:0] synchronise, bit [2] is the previous synchronised level, so an
  // event is decided on the 2nd edge and acted on at the 3rd.
  assign ss_sync_d  = {ss_sync_q[1:0], btn_ss};
  assign clr_sync_d = {clr_sync_q[1:0], btn_clr};
  assign ss_ev      = ss_sync_q[1] & ~ss_sync_q[2];
  assign clr_ev     = clr_sync_q[1] & ~clr_sync_q[2];

`ifdef STOPWATCH_LAP_EN
  logic [2:0] lap_sync_q, lap_sync_d;
  digits_t    lap_q, lap_d;

  assign lap_sync_d = {lap_sync_q[1:0], btn_lap};
  assign lap_ev     = lap_sync_q[1] & ~lap_sync_q[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_sync_q <= '0;
      lap_q      <= '0;
    end else begin
      lap_sync_q <= lap_sync_d;
      lap_q      <= lap_d;
    end
  end
`else
  assign lap_ev = 1'b0;
`endif

  assign running   = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign limit_hit = running && (min_in == LIMIT);

  always_comb begin
    state_d  = state_q;
    clr_take = 1'b0;
    if (limit_hit) begin
      state_d = ST_DONE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (clr_ev) begin
            state_d  = ST_IDLE;
            clr_take = 1'b1;
          end else if (ss_ev) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (ss_ev)       state_d = ST_PAUSE;
          else if (lap_ev) state_d = ST_LAP;
        end
        ST_LAP: begin
          if (ss_ev)       state_d = ST_PAUSE;
          else if (lap_ev) state_d = ST_RUN;
        end
        ST_PAUSE: begin
          if (clr_ev) begin
            state_d  = ST_IDLE;
            clr_take = 1'b1;
          end else if (ss_ev) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          if (clr_ev) begin
            state_d  = ST_IDLE;
            clr_take = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign div_clr = clr_take || (state_q == ST_IDLE && state_d == ST_RUN);

  tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .run  (running),
    .clr  (div_clr),
    .tick (tick)
  );

  // A tick landing on the cycle the limit is seen is swallowed so no count
  // pulse shows up once DONE is reached.
  assign cnt_en_d  = tick & ~limit_hit;
  assign cnt_clr_d = clr_take;

  always_comb begin
    disp_d = live;
`ifdef STOPWATCH_LAP_EN
    lap_d = lap_q;
    if (state_q == ST_RUN && state_d == ST_LAP) lap_d = live;
    if (state_q == ST_LAP && state_d == ST_LAP) disp_d = lap_q;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ss_sync_q  <= '0;
      clr_sync_q <= '0;
      cnt_en_q   <= 1'b0;
      cnt_clr_q  <= 1'b0;
      disp_q     <= '0;
    end else begin
      state_q    <= state_d;
      ss_sync_q  <= ss_sync_d;
      clr_sync_q <= clr_sync_d;
      cnt_en_q   <= cnt_en_d;
      cnt_clr_q  <= cnt_clr_d;
      disp_q     <= disp_d;
    end
  end

  assign cnt_en     = cnt_en_q;
  assign cnt_clr    = cnt_clr_q;
  assign disp_min   = disp_q.min;
  assign disp_seg2  = disp_q.seg2;
  assign disp_seg1  = disp_q.seg1;
  assign disp_deci  = disp_q.deci;
  assign disp_centi = disp_q.centi;
  assign disp_milli = disp_q.milli;
  assign state_o    = state_q;
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
//   Directed plus randomized bench for stopwatch_ctrl (CLK_HZ=10, TICK_HZ=1).
//   A behavioural model tracks mode, tick phase and display from the button
//   history and digit inputs; every cycle's outputs are compared against it.
module tb_stopwatch_ctrl;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_ss = 1'b0, btn_lap = 1'b0, btn_clr = 1'b0;
  logic [3:0] min_in = 0, seg2_in = 0, seg1_in = 0, deci_in = 0, centi_in = 0, milli_in = 0;
  logic       cnt_en, cnt_clr, done;
  logic [3:0] disp_min, disp_seg2, disp_seg1, disp_deci, disp_centi, disp_milli;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;
  bit rnd_dig = 0;
  bit rnd_lim = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .LIMIT_MIN(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_ss    (btn_ss),
`ifdef STOPWATCH_LAP_EN
    .btn_lap   (btn_lap),
`endif
    .btn_clr   (btn_clr),
    .min_in    (min_in),
    .seg2_in   (seg2_in),
    .seg1_in   (seg1_in),
    .deci_in   (deci_in),
    .centi_in  (centi_in),
    .milli_in  (milli_in),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .disp_min  (disp_min),
    .disp_seg2 (disp_seg2),
    .disp_seg1 (disp_seg1),
    .disp_deci (disp_deci),
    .disp_centi(disp_centi),
    .disp_milli(disp_milli),
    .state_o   (state_o),
    .done      (done)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0] st;
    logic [3:0] dv;
    logic       en;
    logic       clr;
  } mres_t;

  logic [2:0] m_state = 0;
  logic [3:0] m_div = 0;
  logic       m_en = 0, m_clr = 0;
  logic [3:0] m_disp [6] = '{default: 4'd0};
  logic [2:0] h_ss = 0, h_clr = 0, h_lap = 0;
  logic       ev_ss, ev_clr, ev_lap;
  mres_t      m_nx;

  // A button acts on the edge where its level two samples ago is 1 and three
  // samples ago is 0 (h[0] is the latest sample).
  assign ev_ss  = h_ss[1] & ~h_ss[2];
  assign ev_clr = h_clr[1] & ~h_clr[2];
`ifdef STOPWATCH_LAP_EN
  assign ev_lap = h_lap[1] & ~h_lap[2];
`else
  assign ev_lap = 1'b0;
`endif

  // Modes: 0 idle, 1 run, 2 pause, 3 lap, 4 done.
  function automatic mres_t model_next(input logic [2:0] st, input logic [3:0] dv,
                                       input logic ss, input logic clr, input logic lap,
                                       input logic [3:0] mn);
    mres_t r;
    logic  counting, lim;
    counting = (st == 3'd1) || (st == 3'd3);
    lim      = counting && (mn == 4'd2);
    r.st  = st;
    r.clr = 1'b0;
    if (lim) r.st = 3'd4;
    else if (clr && (st == 3'd0 || st == 3'd2 || st == 3'd4)) begin
      r.st  = 3'd0;
      r.clr = 1'b1;
    end else if (ss && st != 3'd4) r.st = counting ? 3'd2 : 3'd1;
    else if (lap && st == 3'd1) r.st = 3'd3;
    else if (lap && st == 3'd3) r.st = 3'd1;
    r.en = counting && (int'(dv) == DIV - 1) && !lim;
    if (r.clr || (st == 3'd0 && r.st == 3'd1)) r.dv = 4'd0;
    else if (counting) r.dv = (int'(dv) == DIV - 1) ? 4'd0 : dv + 4'd1;
    else r.dv = dv;
    return r;
  endfunction

  assign m_nx = model_next(m_state, m_div, ev_ss, ev_clr, ev_lap, min_in);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state <= 0; m_div <= 0; m_en <= 0; m_clr <= 0;
      h_ss <= 0; h_clr <= 0; h_lap <= 0;
      for (int i = 0; i < 6; i++) m_disp[i] <= 4'd0;
    end else begin
      m_state <= m_nx.st;
      m_div   <= m_nx.dv;
      m_en    <= m_nx.en;
      m_clr   <= m_nx.clr;
      h_ss    <= {h_ss[1:0], btn_ss};
      h_clr   <= {h_clr[1:0], btn_clr};
      h_lap   <= {h_lap[1:0], btn_lap};
      if (!(m_state == 3'd3 && m_nx.st == 3'd3)) begin
        m_disp[0] <= min_in;  m_disp[1] <= seg2_in;  m_disp[2] <= seg1_in;
        m_disp[3] <= deci_in; m_disp[4] <= centi_in; m_disp[5] <= milli_in;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("state", state_o, m_state);
    chk("cnt_en", cnt_en, m_en);
    chk("cnt_clr", cnt_clr, m_clr);
    chk("done", done, m_state == 3'd4);
    chk("disp_min", disp_min, m_disp[0]);
    chk("disp_seg2", disp_seg2, m_disp[1]);
    chk("disp_seg1", disp_seg1, m_disp[2]);
    chk("disp_deci", disp_deci, m_disp[3]);
    chk("disp_centi", disp_centi, m_disp[4]);
    chk("disp_milli", disp_milli, m_disp[5]);
  endtask

  task automatic rand_digits();
    seg2_in  = 4'($urandom_range(0, 9));
    seg1_in  = 4'($urandom_range(0, 9));
    deci_in  = 4'($urandom_range(0, 9));
    centi_in = 4'($urandom_range(0, 9));
    milli_in = 4'($urandom_range(0, 9));
    if (rnd_lim && $urandom_range(0, 39) == 0) min_in = 4'd2;
    else min_in = 4'($urandom_range(0, 1));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_all();
      if (rnd_dig) rand_digits();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int gap;
    milli_in = 4'd5;
    min_in   = 4'd1;
    #2 reset = 1'b1;
    #20;
    chk("rst_state", state_o, 3'd0);
    chk("rst_cnt_en", cnt_en, 1'b0);
    chk("rst_cnt_clr", cnt_clr, 1'b0);
    chk("rst_disp_milli", disp_milli, 4'd0);
    chk("rst_disp_min", disp_min, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    min_in = 4'd0;
    rnd_dig = 1'b1;

    // start: RUN on the 3rd edge, first cnt_en DIV cycles later, then every DIV
    btn_ss = 1'b1;
    step(2);
    chk("t1_not_yet", state_o, 3'd0);
    step(1);
    chk("t1_run", state_o, 3'd1);
    for (int k = 1; k <= 2 * DIV; k++) begin
      step(1);
      if (k == 4) btn_ss = 1'b0;
      if (k == DIV || k == 2 * DIV) chk("t1_cnt_en_hi", cnt_en, 1'b1);
      else chk("t1_cnt_en_lo", cnt_en, 1'b0);
    end

    // pause keeps the tick phase; resume finishes the remaining count
    step(3);
    btn_ss = 1'b1;
    step(3);
    chk("t2_pause", state_o, 3'd2);
    btn_ss = 1'b0;
    step(20);
    chk("t2_still_pause", state_o, 3'd2);
    btn_ss = 1'b1;
    step(3);
    chk("t2_resume", state_o, 3'd1);
    btn_ss = 1'b0;
    gap = 0;
    while (cnt_en !== 1'b1 && gap < 20) begin
      step(1);
      gap++;
    end
    chk("t2_gap", gap, 4);

`ifdef STOPWATCH_LAP_EN
    // lap freezes the display while counting continues
    rnd_dig  = 1'b0;
    min_in   = 4'd0;
    milli_in = 4'd7;
    btn_lap  = 1'b1;
    step(3);
    chk("t3_lap", state_o, 3'd3);
    btn_lap  = 1'b0;
    milli_in = 4'd3;
    step(2);
    chk("t3_frozen", disp_milli, 4'd7);
    milli_in = 4'd5;
    btn_lap  = 1'b1;
    step(3);
    chk("t3_unlap", state_o, 3'd1);
    chk("t3_live", disp_milli, 4'd5);
    btn_lap = 1'b0;
    step(1);
`endif

    // clear is ignored while running
    rnd_dig = 1'b0;
    min_in  = 4'd0;
    btn_clr = 1'b1;
    step(3);
    chk("t5_clr_run_state", state_o, 3'd1);
    chk("t5_clr_run_pulse", cnt_clr, 1'b0);
    btn_clr = 1'b0;
    step(1);

    // minute limit -> DONE; ss ignored; clr -> IDLE with one-cycle cnt_clr
    min_in = 4'd2;
    step(1);
    chk("t4_done_state", state_o, 3'd4);
    chk("t4_done_flag", done, 1'b1);
    step(12);
    chk("t4_no_cnt_en", cnt_en, 1'b0);
    min_in = 4'd0;
    btn_ss = 1'b1;
    step(4);
    chk("t4_ss_ignored", state_o, 3'd4);
    btn_ss  = 1'b0;
    btn_clr = 1'b1;
    step(3);
    chk("t4_clr_pulse", cnt_clr, 1'b1);
    chk("t4_idle", state_o, 3'd0);
    step(1);
    chk("t4_clr_one_cycle", cnt_clr, 1'b0);
    btn_clr = 1'b0;
    step(1);

    // ss and clr together in PAUSE: clear wins
    btn_ss = 1'b1;
    step(3);
    btn_ss = 1'b0;
    step(4);
    btn_ss = 1'b1;
    step(3);
    chk("t5_pause", state_o, 3'd2);
    btn_ss = 1'b0;
    step(2);
    btn_ss  = 1'b1;
    btn_clr = 1'b1;
    step(3);
    chk("t5_clr_wins", state_o, 3'd0);
    chk("t5_clr_wins_pulse", cnt_clr, 1'b1);
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
    step(2);

    // randomized buttons and digits, occasional minute limit
    rnd_dig = 1'b1;
    rnd_lim = 1'b1;
    for (int n = 0; n < 600; n++) begin
      step(1);
      case ($urandom_range(0, 11))
        0: btn_ss  = ~btn_ss;
        1: btn_clr = ~btn_clr;
        2: btn_lap = ~btn_lap;
        default: ;
      endcase
    end

    // reset mid-run
    rnd_lim = 1'b0;
    btn_ss = 1'b0; btn_clr = 1'b0; btn_lap = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    step(3);
    btn_ss = 1'b1;
    step(3);
    chk("t6_run", state_o, 3'd1);
    step(14);
    btn_ss = 1'b0;
    milli_in = 4'd8;
    reset = 1'b1;
    #1;
    chk("t6_state", state_o, 3'd0);
    chk("t6_cnt_en", cnt_en, 1'b0);
    chk("t6_cnt_clr", cnt_clr, 1'b0);
    chk("t6_done", done, 1'b0);
    chk("t6_disp_milli", disp_milli, 4'd0);
    check_all();
    #10 reset = 1'b0;
    step(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
